// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding, SPI mode constant and the
// default word/divider settings used by both the master and slave controllers.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    XFER  = 3'd2,
    GAP   = 3'd3,
    HOLD  = 3'd4
  } spi_state_e;

  // {CPOL, CPHA}
  localparam logic [1:0] SPI_MODE0 = 2'b00;

  localparam int SPI_DATA_W_DEF   = 8;
  localparam int SPI_CLK_DIV_DEF  = 4;
  localparam int SPI_SS_GUARD_DEF = 4;

endpackage

// File: rtl/spi_sck_gen.sv
// SCK generator: divides clk by CLK_DIV per half-period while enabled and
// flags the clk cycle on which SCK leaves (rise_evt) or returns to (fall_evt) idle.
module spi_sck_gen
  import spi_pkg::*;
#(
  parameter int CLK_DIV = SPI_CLK_DIV_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic sck,
  output logic rise_evt,
  output logic fall_evt
);

  localparam int            DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic          SCK_IDLE = SPI_MODE0[1];

  logic [DW-1:0] div_q;
  logic [DW-1:0] div_d;
  logic          sck_q;
  logic          sck_d;
  logic          tick_s;

  // Divider count and SCK toggle; disabling parks both at their idle values.
  always_comb begin
    div_d  = '0;
    sck_d  = SCK_IDLE;
    tick_s = 1'b0;
    if (en) begin
      tick_s = (div_q == DIV_LAST);
      if (tick_s) begin
        div_d = '0;
        sck_d = ~sck_q;
      end else begin
        div_d = div_q + DW'(1);
        sck_d = sck_q;
      end
    end else begin
      div_d = '0;
      sck_d = SCK_IDLE;
    end
  end

  // Divider and SCK registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      sck_q <= SCK_IDLE;
    end else begin
      div_q <= div_d;
      sck_q <= sck_d;
    end
  end

  assign sck      = sck_q;
  assign rise_evt = tick_s && (sck_q == SCK_IDLE);
  assign fall_evt = tick_s && (sck_q != SCK_IDLE);

endmodule

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: SPI mode 0 master, MSB first, one word per accepted byte;
// tx_last decides whether SS is released after the word or held for the next.
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int DATA_W   = SPI_DATA_W_DEF,
  parameter int CLK_DIV  = SPI_CLK_DIV_DEF,
  parameter int SS_GUARD = SPI_SS_GUARD_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_last,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              SCK,
  output logic              SS,
  output logic              MOSI,
  input  logic              MISO
);

  localparam int            BW         = $clog2(DATA_W);
  localparam int            GW         = (SS_GUARD > 1) ? $clog2(SS_GUARD) : 1;
  localparam logic [BW-1:0] BIT_LAST   = BW'(DATA_W - 1);
  localparam logic [GW-1:0] GUARD_LAST = GW'(SS_GUARD - 1);

  spi_state_e        state_q;
  spi_state_e        state_d;
  logic              ss_q;
  logic              ss_d;
  logic              busy_q;
  logic              busy_d;
  logic              mosi_q;
  logic              mosi_d;
  // MSB goes straight to MOSI on load, so only the remaining bits are kept.
  logic [DATA_W-2:0] tx_shift_q;
  logic [DATA_W-2:0] tx_shift_d;
  logic [DATA_W-1:0] rx_shift_q;
  logic [DATA_W-1:0] rx_shift_d;
  logic              last_q;
  logic              last_d;
  logic [BW-1:0]     bit_cnt_q;
  logic [BW-1:0]     bit_cnt_d;
  logic [GW-1:0]     guard_q;
  logic [GW-1:0]     guard_d;
  logic [DATA_W-1:0] rx_data_q;
  logic [DATA_W-1:0] rx_data_d;
  logic              rx_valid_q;
  logic              rx_valid_d;
  logic              miso_s1_q;
  logic              miso_s2_q;

  logic              tx_ready_s;
  logic              accept_s;
  logic              sck_en_s;
  logic              sck_s;
  logic              rise_evt_s;
  logic              fall_evt_s;

  assign tx_ready_s = (state_q == IDLE) || (state_q == GAP);
  assign accept_s   = tx_valid && tx_ready_s;
  assign sck_en_s   = (state_q == XFER);

  spi_sck_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sck_gen (
    .clk      (clk),
    .rst_n    (rst),
    .en       (sck_en_s),
    .sck      (sck_s),
    .rise_evt (rise_evt_s),
    .fall_evt (fall_evt_s)
  );

  // Two-flop synchroniser for MISO.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      miso_s1_q <= 1'b0;
      miso_s2_q <= 1'b0;
    end else begin
      miso_s1_q <= MISO;
      miso_s2_q <= miso_s1_q;
    end
  end

  // Next-state and datapath for the frame sequencer.
  always_comb begin
    state_d    = state_q;
    ss_d       = ss_q;
    busy_d     = busy_q;
    mosi_d     = mosi_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    last_d     = last_q;
    bit_cnt_d  = bit_cnt_q;
    guard_d    = guard_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d = SETUP;
          ss_d    = 1'b0;
          busy_d  = 1'b1;
          guard_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      SETUP: begin
        if (guard_q == GUARD_LAST) begin
          state_d   = XFER;
          guard_d   = '0;
          bit_cnt_d = '0;
        end else begin
          guard_d = guard_q + GW'(1);
        end
      end
      XFER: begin
        if (rise_evt_s) begin
          rx_shift_d = {rx_shift_q[DATA_W-2:0], miso_s2_q};
        end else if (fall_evt_s) begin
          if (bit_cnt_q != BIT_LAST) begin
            mosi_d     = tx_shift_q[DATA_W-2];
            tx_shift_d = tx_shift_q << 1;
            bit_cnt_d  = bit_cnt_q + BW'(1);
          end else begin
            rx_data_d  = rx_shift_q;
            rx_valid_d = 1'b1;
            bit_cnt_d  = '0;
            guard_d    = '0;
            state_d    = last_q ? HOLD : GAP;
          end
        end else begin
          state_d = XFER;
        end
      end
      GAP: begin
        if (accept_s) begin
          state_d = XFER;
        end else begin
          state_d = GAP;
        end
      end
      HOLD: begin
        if (guard_q == GUARD_LAST) begin
          state_d = IDLE;
          ss_d    = 1'b1;
          busy_d  = 1'b0;
          mosi_d  = 1'b0;
          guard_d = '0;
        end else begin
          guard_d = guard_q + GW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        ss_d    = 1'b1;
        busy_d  = 1'b0;
        mosi_d  = 1'b0;
      end
    endcase

    // Byte load is common to IDLE and GAP acceptance.
    if (accept_s) begin
      mosi_d     = tx_data[DATA_W-1];
      tx_shift_d = tx_data[DATA_W-2:0];
      last_d     = tx_last;
      rx_shift_d = '0;
      bit_cnt_d  = '0;
    end else begin
      last_d = last_q;
    end
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      ss_q       <= 1'b1;
      busy_q     <= 1'b0;
      mosi_q     <= 1'b0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      last_q     <= 1'b0;
      bit_cnt_q  <= '0;
      guard_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ss_q       <= ss_d;
      busy_q     <= busy_d;
      mosi_q     <= mosi_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      last_q     <= last_d;
      bit_cnt_q  <= bit_cnt_d;
      guard_q    <= guard_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign tx_ready = tx_ready_s;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy     = busy_q;
  assign SCK      = sck_s;
  assign SS       = ss_q;
  assign MOSI     = mosi_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl (DATA_W=8, CLK_DIV=2, SS_GUARD=2) with a
// mode 0 slave model on MISO and passive SCK/SS/MOSI monitors.
module tb_spi_master_ctrl;

  localparam int DATA_W   = 8;
  localparam int CLK_DIV  = 2;
  localparam int SS_GUARD = 2;

  logic        clk;
  logic        rst;
  logic [7:0]  tx_data;
  logic        tx_last;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        busy;
  logic        SCK;
  logic        SS;
  logic        MOSI;
  logic        MISO;

  int vectors     = 0;
  int miscompares = 0;

  spi_master_ctrl #(
    .DATA_W   (DATA_W),
    .CLK_DIV  (CLK_DIV),
    .SS_GUARD (SS_GUARD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_data  (tx_data),
    .tx_last  (tx_last),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .busy     (busy),
    .SCK      (SCK),
    .SS       (SS),
    .MOSI     (MOSI),
    .MISO     (MISO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave model: presents its byte on SS fall, advances after each sampling
  // edge so the master's MISO synchroniser delay stays inside the half period.
  logic [7:0] slv_byte  = 8'h00;
  logic [7:0] slv_shift = 8'h00;
  logic       slv_armed = 1'b1;
  int         slv_cnt   = 0;
  always @(SS or posedge SCK) begin
    if (SS) begin
      slv_cnt   = 0;
      slv_armed = 1'b1;
      MISO      = 1'b0;
    end else if (slv_armed) begin
      slv_armed = 1'b0;
      slv_cnt   = 0;
      slv_shift = slv_byte;
      MISO      = slv_shift[7];
    end else if (SCK) begin
      slv_cnt = slv_cnt + 1;
      if (slv_cnt == 8) begin
        slv_cnt   = 0;
        slv_shift = slv_byte;
      end else begin
        slv_shift = slv_shift << 1;
      end
      MISO = slv_shift[7];
    end
  end

  int          rise_cnt = 0;
  logic [31:0] mosi_cap = 32'h0;
  time         rise_t [0:511];
  always @(posedge SCK) begin
    rise_t[rise_cnt[8:0]] = $time;
    rise_cnt = rise_cnt + 1;
    mosi_cap = {mosi_cap[30:0], MOSI};
  end

  int   rxv_cnt     = 0;
  int   ss_low_cyc  = 0;
  int   ss_fall_cnt = 0;
  int   ss_rise_cnt = 0;
  int   mosi_viol   = 0;
  int   ss_viol     = 0;
  logic [7:0] rx_last = 8'h00;
  logic mosi_prev = 1'b0;
  logic sck_prev  = 1'b0;
  logic ss_prev   = 1'b1;
  logic rst_prev  = 1'b0;
  always @(negedge clk) begin
    if (rx_valid) begin
      rxv_cnt = rxv_cnt + 1;
      rx_last = rx_data;
    end
    if (!SS) ss_low_cyc = ss_low_cyc + 1;
    if (!SS && ss_prev) ss_fall_cnt = ss_fall_cnt + 1;
    if (SS && !ss_prev) ss_rise_cnt = ss_rise_cnt + 1;
    if (rst && rst_prev) begin
      if ((MOSI !== mosi_prev) && SCK) mosi_viol = mosi_viol + 1;
      if (SS && !ss_prev && (SCK || sck_prev)) ss_viol = ss_viol + 1;
    end
    mosi_prev = MOSI;
    sck_prev  = SCK;
    ss_prev   = SS;
    rst_prev  = rst;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors = vectors + 1;
    assert (obs === exp) else begin
      miscompares = miscompares + 1;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send_byte(input logic [7:0] d, input logic l);
    int n;
    n        = 0;
    tx_data  = d;
    tx_last  = l;
    tx_valid = 1'b1;
    while (!tx_ready && n < 400) begin
      @(negedge clk);
      n = n + 1;
    end
    if (tx_ready) begin
      @(negedge clk);
    end else begin
      check("accept_timeout", 32'(tx_ready), 32'd1);
    end
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (!(SS && !busy) && n < 400) begin
      @(negedge clk);
      n = n + 1;
    end
    check({tag, "_idle_ss"}, 32'(SS), 32'd1);
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!tx_ready && n < 200) begin
      @(negedge clk);
      n = n + 1;
    end
    check({tag, "_gap_ready"}, 32'(tx_ready), 32'd1);
  endtask

  initial begin
    int r0, x0, l0, f0, u0, n, bad, acc_bad;
    logic [7:0] d;
    logic       l;
    time        dt;

    rst      = 1'b0;
    tx_data  = 8'h00;
    tx_last  = 1'b0;
    tx_valid = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_ss",       32'(SS),       32'd1);
    check("rst_sck",      32'(SCK),      32'd0);
    check("rst_mosi",     32'(MOSI),     32'd0);
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_rx_data",  32'(rx_data),  32'h00);
    #2 rst = 1'b1;
    @(negedge clk);
    check("rst_tx_ready", 32'(tx_ready), 32'd1);

    // Single byte 0xA5, slave returns 0x3C
    slv_byte = 8'h3C;
    r0 = rise_cnt; x0 = rxv_cnt; l0 = ss_low_cyc;
    send_byte(8'hA5, 1'b1);
    check("single_busy", 32'(busy), 32'd1);
    wait_idle("single");
    check("single_mosi",   32'(mosi_cap[7:0]),  32'hA5);
    check("single_rises",  32'(rise_cnt - r0),  32'd8);
    check("single_rxv",    32'(rxv_cnt - x0),   32'd1);
    check("single_rxdata", 32'(rx_last),        32'h3C);
    check("single_ss_low", 32'(ss_low_cyc - l0), 32'd36);
    check("single_mosi0",  32'(MOSI),           32'd0);

    // Three-byte frame with a 10-cycle hold-off between bytes
    slv_byte = 8'h96;
    r0 = rise_cnt; x0 = rxv_cnt; f0 = ss_fall_cnt; u0 = ss_rise_cnt;
    send_byte(8'h01, 1'b0);
    wait_ready("frame1");
    repeat (10) @(negedge clk);
    check("frame_gap1_sck", 32'(SCK), 32'd0);
    check("frame_gap1_ss",  32'(SS),  32'd0);
    send_byte(8'h80, 1'b0);
    wait_ready("frame2");
    repeat (10) @(negedge clk);
    check("frame_gap2_sck", 32'(SCK), 32'd0);
    check("frame_gap2_ss",  32'(SS),  32'd0);
    send_byte(8'hFF, 1'b1);
    wait_idle("frame");
    check("frame_mosi",   32'(mosi_cap[23:0]),    32'h0180FF);
    check("frame_rises",  32'(rise_cnt - r0),     32'd24);
    check("frame_rxv",    32'(rxv_cnt - x0),      32'd3);
    check("frame_ss_fall", 32'(ss_fall_cnt - f0), 32'd1);
    check("frame_ss_rise", 32'(ss_rise_cnt - u0), 32'd1);
    check("frame_rxdata", 32'(rx_last),           32'h96);

    // Back-to-back 0x55, 0xAA presented as soon as GAP is reached
    slv_byte = 8'h0F;
    r0 = rise_cnt; l0 = ss_low_cyc;
    send_byte(8'h55, 1'b0);
    send_byte(8'hAA, 1'b1);
    wait_idle("b2b");
    check("b2b_mosi",   32'(mosi_cap[15:0]),   32'h55AA);
    check("b2b_ss_low", 32'(ss_low_cyc - l0),  32'd69);
    bad = 0;
    for (int i = 1; i < 16; i++) begin
      dt = rise_t[9'((r0 + i) % 512)] - rise_t[9'((r0 + i - 1) % 512)];
      if (i != 8 && dt != 40) bad = bad + 1;
    end
    check("b2b_uniform", 32'(bad), 32'd0);
    dt = rise_t[9'((r0 + 8) % 512)] - rise_t[9'((r0 + 7) % 512)];
    check("b2b_boundary", 32'(dt), 32'd50);

    // Reset after the 4th rising edge of 0xF0
    slv_byte = 8'hC3;
    r0 = rise_cnt; x0 = rxv_cnt;
    send_byte(8'hF0, 1'b1);
    n = 0;
    while ((rise_cnt - r0) < 4 && n < 200) begin
      @(negedge clk);
      n = n + 1;
    end
    check("rst_mid_sck_pre", 32'(SCK), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("rst_mid_ss",   32'(SS),   32'd1);
    check("rst_mid_sck",  32'(SCK),  32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    check("rst_mid_ready", 32'(tx_ready),     32'd1);
    check("rst_mid_rxv",   32'(rxv_cnt - x0), 32'd0);
    send_byte(8'h0F, 1'b1);
    wait_idle("after_rst");
    check("after_rst_mosi",   32'(mosi_cap[7:0]), 32'h0F);
    check("after_rst_rxdata", 32'(rx_last),       32'hC3);
    check("after_rst_rxv",    32'(rxv_cnt - x0),  32'd1);

    // Garbage tx_valid toggling during XFER
    slv_byte = 8'h5A;
    x0 = rxv_cnt; f0 = ss_fall_cnt;
    send_byte(8'h3A, 1'b1);
    acc_bad = 0;
    for (int i = 0; i < 20; i++) begin
      tx_data  = 8'hDE;
      tx_last  = 1'b1;
      tx_valid = (i % 2 == 0);
      @(negedge clk);
      if (tx_ready) acc_bad = acc_bad + 1;
    end
    tx_valid = 1'b0;
    wait_idle("garbage");
    repeat (4) @(negedge clk);
    check("garbage_ready",   32'(acc_bad),             32'd0);
    check("garbage_mosi",    32'(mosi_cap[7:0]),       32'h3A);
    check("garbage_ss_fall", 32'(ss_fall_cnt - f0),    32'd1);
    check("garbage_rxv",     32'(rxv_cnt - x0),        32'd1);
    check("garbage_ss_idle", 32'(SS),                  32'd1);

    // Random 200-byte run under the protocol monitors
    x0 = rxv_cnt; r0 = rise_cnt;
    d = 8'h00;
    for (int i = 0; i < 200; i++) begin
      d = 8'($urandom);
      l = (i == 199) ? 1'b1 : ($urandom_range(0, 3) == 0);
      send_byte(d, l);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_idle("random");
    check("random_rxv",       32'(rxv_cnt - x0),  32'd200);
    check("random_rises",     32'(rise_cnt - r0), 32'd1600);
    check("random_last_mosi", 32'(mosi_cap[7:0]), 32'(d));
    check("random_rxdata",    32'(rx_last),       32'h5A);
    check("mon_mosi_stable",  32'(mosi_viol),     32'd0);
    check("mon_ss_sck",       32'(ss_viol),       32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
